// File: rtl/adaptive_backlight_ctrl_if.sv
// Video tap and backlight-result bundle for adaptive_backlight_ctrl.
// Video inputs are sampled on every clock and carry no backpressure.
// The result side provides pwm_value, which always holds the current duty,
// and pwm_valid, which pulses for one clock whenever frame statistics
// refresh the result set.
interface adaptive_backlight_ctrl_if;
  logic       de;
  logic       vsync;
  logic       hsync;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       enable;
  logic [9:0] pwm_value;
  logic       pwm_valid;
  logic [7:0] frame_mean;
  logic [7:0] frame_peak;
  logic [1:0] fsm_state;

  modport master (
    output de, vsync, hsync, r, g, b, enable,
    input  pwm_value, pwm_valid, frame_mean, frame_peak, fsm_state
  );

  modport slave (
    input  de, vsync, hsync, r, g, b, enable,
    output pwm_value, pwm_valid, frame_mean, frame_peak, fsm_state
  );
endinterface

// File: rtl/adaptive_backlight_ctrl.sv
// Per-frame brightness statistics mapped to a slew-limited backlight duty.
// Accumulates max(R,G,B) over each frame. At each vsync rising edge it divides
// sum by count (32 serial cycles), maps the mean to 10 bits, and moves the
// duty toward that target by at most MAX_STEP LSBs per frame.
module adaptive_backlight_ctrl #(
  parameter int MAX_STEP = 16,
  parameter int MIN_PWM  = 64
) (
  input logic                      clk,
  input logic                      reset_n,
  adaptive_backlight_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, MAP = 2'd2, SLEW = 2'd3} state_t;

  localparam logic [9:0]  MAX_STEP_V = 10'(MAX_STEP);
  localparam logic [9:0]  MIN_PWM_V  = 10'(MIN_PWM);
  localparam logic [23:0] CNT_FULL   = 24'hFF_FFFF;

  state_t      state_q, state_d;
  logic        vsync_d;
  logic        frame_edge;
  logic        capture;
  logic [7:0]  pix_max;
  logic [31:0] acc_sum;
  logic [23:0] acc_cnt;
  logic [7:0]  acc_peak;
  logic [31:0] div_num;   // dividend, shifted out as quotient bits shift in
  logic [23:0] div_den;
  logic [23:0] div_rem;
  logic [4:0]  div_bit;
  logic [7:0]  peak_cap;
  logic [24:0] rem_shift;
  logic [24:0] rem_sub;
  logic        rem_ge;
  logic [7:0]  mean_q;
  logic [9:0]  target_q;
  logic [9:0]  cur;
  logic [9:0]  slew_next;
  logic [9:0]  map_raw;
  logic [9:0]  map_target;
  logic [7:0]  quot_mean;
  logic        valid_q;
  logic [7:0]  mean_out;
  logic [7:0]  peak_out;

  assign frame_edge = bus.vsync & ~vsync_d;
  assign capture    = (state_q == IDLE) && frame_edge;

  // Brightest channel of the current pixel.
  always_comb begin
    pix_max = bus.r;
    if (bus.g > pix_max) pix_max = bus.g;
    if (bus.b > pix_max) pix_max = bus.b;
  end

  // Next state; an edge arriving outside IDLE is ignored by the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_edge) state_d = DIV;
      DIV:     if (div_bit == 5'd31) state_d = MAP;
      MAP:     state_d = SLEW;
      SLEW:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Edge detector; resets high so a vsync held through reset is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vsync_d <= 1'b1;
    else          vsync_d <= bus.vsync;
  end

  // Frame accumulators; a pixel in the edge cycle opens the new frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_sum  <= '0;
      acc_cnt  <= '0;
      acc_peak <= '0;
    end else if (frame_edge) begin
      acc_sum  <= bus.de ? {24'd0, pix_max} : 32'd0;
      acc_cnt  <= bus.de ? 24'd1 : 24'd0;
      acc_peak <= bus.de ? pix_max : 8'd0;
    end else if (bus.de) begin
      if (acc_cnt != CNT_FULL) begin
        acc_sum <= acc_sum + {24'd0, pix_max};
        acc_cnt <= acc_cnt + 24'd1;
      end
      if (pix_max > acc_peak) acc_peak <= pix_max;
    end
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {div_rem, div_num[31]};
    rem_sub   = rem_shift - {1'b0, div_den};
    rem_ge    = rem_shift >= {1'b0, div_den};
  end

  // Divider registers: loaded on capture, one quotient bit per DIV cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_num  <= '0;
      div_den  <= '0;
      div_rem  <= '0;
      div_bit  <= '0;
      peak_cap <= '0;
    end else if (capture) begin
      div_num  <= acc_sum;
      div_den  <= acc_cnt;
      div_rem  <= '0;
      div_bit  <= '0;
      peak_cap <= acc_peak;
    end else if (state_q == DIV) begin
      div_rem <= rem_ge ? rem_sub[23:0] : rem_shift[23:0];
      div_num <= {div_num[30:0], rem_ge};
      div_bit <= div_bit + 5'd1;
    end
  end

  // Mean to duty: 4*mean + mean/64 spans 0..1023, floored at MIN_PWM.
  always_comb begin
    quot_mean  = (div_den == 24'd0) ? 8'd0 : div_num[7:0];
    map_raw    = {quot_mean, 2'b00} + {8'd0, quot_mean[7:6]};
    map_target = (map_raw < MIN_PWM_V) ? MIN_PWM_V : map_raw;
  end

  // Mapped mean and target held for the slew cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mean_q   <= '0;
      target_q <= '0;
    end else if (state_q == MAP) begin
      mean_q   <= quot_mean;
      target_q <= map_target;
    end
  end

  // Move cur toward target by at most MAX_STEP; differences never wrap.
  always_comb begin
    slew_next = cur;
    if (target_q > cur) begin
      if ((target_q - cur) > MAX_STEP_V) slew_next = cur + MAX_STEP_V;
      else                               slew_next = target_q;
    end else if (target_q < cur) begin
      if ((cur - target_q) > MAX_STEP_V) slew_next = cur - MAX_STEP_V;
      else                               slew_next = target_q;
    end
  end

  // Duty register; disable pins it at full scale so re-enable slews from 1023.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cur <= 10'd1023;
    else if (!bus.enable)      cur <= 10'd1023;
    else if (state_q == SLEW)  cur <= slew_next;
  end

  // Published statistics and the one-cycle update strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      mean_out <= '0;
      peak_out <= '0;
    end else begin
      valid_q <= (state_q == SLEW);
      if (state_q == SLEW) begin
        mean_out <= mean_q;
        peak_out <= peak_cap;
      end
    end
  end

  assign bus.pwm_value  = cur;
  assign bus.pwm_valid  = valid_q;
  assign bus.frame_mean = mean_out;
  assign bus.frame_peak = peak_out;
  assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_adaptive_backlight_ctrl.sv
// Directed bench for adaptive_backlight_ctrl: reset, convergence, mixed and
// empty frames, overrun drop, enable bypass and reset during the divide.
module tb_adaptive_backlight_ctrl;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  adaptive_backlight_ctrl_if bus ();

  adaptive_backlight_ctrl #(.MAX_STEP(16), .MIN_PWM(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: n consecutive pixels of one colour, then de low.
  task automatic drive_pix(input int n, input logic [7:0] rv, input logic [7:0] gv,
                           input logic [7:0] bv);
    for (int i = 0; i < n; i++) begin
      bus.de = 1'b1;
      bus.r  = rv;
      bus.g  = gv;
      bus.b  = bv;
      tick();
    end
    bus.de = 1'b0;
  endtask

  // Raise vsync, watch 40 cycles, expect a single strobe at E+35 with given results.
  task automatic do_edge(input string tag, input logic [7:0] exp_mean,
                         input logic [7:0] exp_peak, input logic [9:0] exp_pwm);
    int pulses;
    int at;
    logic [7:0] mean_c;
    logic [7:0] peak_c;
    logic [9:0] pwm_c;
    pulses = 0;
    at     = 0;
    mean_c = '0;
    peak_c = '0;
    pwm_c  = '0;
    bus.vsync = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 2) bus.vsync = 1'b0;
      if (bus.pwm_valid) begin
        pulses++;
        at     = k;
        mean_c = bus.frame_mean;
        peak_c = bus.frame_peak;
        pwm_c  = bus.pwm_value;
      end
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_latency"}, at, 35);
    check({tag, "_mean"}, mean_c, exp_mean);
    check({tag, "_peak"}, peak_c, exp_peak);
    check({tag, "_pwm"}, pwm_c, exp_pwm);
  endtask

  initial begin
    int exp_pwm;
    int pulses;
    int at;
    int holds;
    logic [7:0] mean_c;
    logic [7:0] peak_c;
    logic [9:0] pwm_c;
    n_checks = 0;
    n_pass   = 0;
    reset_n    = 1'b0;
    bus.de     = 1'b0;
    bus.vsync  = 1'b1;
    bus.hsync  = 1'b0;
    bus.r      = '0;
    bus.g      = '0;
    bus.b      = '0;
    bus.enable = 1'b1;

    // Reset with vsync held high: no edge on release.
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_pwm", bus.pwm_value, 1023);
    check("rst_valid", bus.pwm_valid, 0);
    check("rst_mean", bus.frame_mean, 0);
    check("rst_peak", bus.frame_peak, 0);
    check("rst_state", bus.fsm_state, 0);
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.pwm_valid) pulses++;
    end
    check("rst_no_pulse", pulses, 0);
    bus.vsync = 1'b0;
    repeat (2) tick();

    // Uniform frames: 1007, 991, ... 815, 803, then holding at 803.
    exp_pwm = 1023;
    for (int f = 0; f < 16; f++) begin
      exp_pwm = (exp_pwm - 803 > 16) ? exp_pwm - 16 : 803;
      drive_pix(100, 8'd200, 8'd10, 8'd50);
      do_edge("uniform", 8'd200, 8'd200, 10'(exp_pwm));
    end
    check("converged", bus.pwm_value, 803);

    // Enable off: still 803 this cycle, 1023 after the next edge.
    bus.enable = 1'b0;
    #1;
    check("dis_same_cycle", bus.pwm_value, 803);
    tick();
    check("dis_next_cycle", bus.pwm_value, 1023);
    drive_pix(100, 8'd200, 8'd10, 8'd50);
    do_edge("disabled", 8'd200, 8'd200, 10'd1023);
    bus.enable = 1'b1;
    drive_pix(100, 8'd200, 8'd10, 8'd50);
    do_edge("reenable", 8'd200, 8'd200, 10'd1007);

    // Mixed frame: (255+255+0+0)/4 = 127, target 509, step down from 1007.
    drive_pix(2, 8'd0, 8'd255, 8'd3);
    drive_pix(2, 8'd0, 8'd0, 8'd0);
    do_edge("mixed", 8'd127, 8'd255, 10'd991);

    // Empty frames: target clamps to 64, step down 16 per frame then hold.
    exp_pwm = 991;
    holds   = 0;
    for (int f = 0; f < 80 && holds < 2; f++) begin
      if (exp_pwm == 64) holds++;
      exp_pwm = (exp_pwm - 64 > 16) ? exp_pwm - 16 : 64;
      do_edge("empty", 8'd0, 8'd0, 10'(exp_pwm));
    end
    check("empty_floor", bus.pwm_value, 64);

    // Overrun: second edge at E+10 is dropped along with its pixels.
    drive_pix(10, 8'd100, 8'd0, 8'd0);
    bus.vsync = 1'b1;
    pulses = 0;
    at     = 0;
    mean_c = '0;
    peak_c = '0;
    pwm_c  = '0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      bus.de = 1'b0;
      if (k == 2) bus.vsync = 1'b0;
      if (k >= 3 && k <= 8) begin
        bus.de = 1'b1;
        bus.r  = 8'd250;
      end
      if (k == 10) bus.vsync = 1'b1;
      if (k == 12) bus.vsync = 1'b0;
      if (k >= 14 && k <= 23) begin
        bus.de = 1'b1;
        bus.r  = 8'd50;
      end
      if (bus.pwm_valid) begin
        pulses++;
        at     = k;
        mean_c = bus.frame_mean;
        peak_c = bus.frame_peak;
        pwm_c  = bus.pwm_value;
      end
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_latency", at, 35);
    check("ovr_mean", mean_c, 100);
    check("ovr_peak", peak_c, 100);
    check("ovr_pwm", pwm_c, 80);
    do_edge("after_ovr", 8'd50, 8'd50, 10'd96);

    // Reset asserted at E+20 aborts the divide.
    drive_pix(10, 8'd30, 8'd30, 8'd30);
    bus.vsync = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) bus.vsync = 1'b0;
    end
    check("mid_state_div", bus.fsm_state, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_pwm", bus.pwm_value, 1023);
    check("mid_rst_valid", bus.pwm_valid, 0);
    check("mid_rst_mean", bus.frame_mean, 0);
    check("mid_rst_peak", bus.frame_peak, 0);
    check("mid_rst_state", bus.fsm_state, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.pwm_valid) pulses++;
    end
    check("mid_rst_no_pulse", pulses, 0);
    check("mid_rst_pwm_hold", bus.pwm_value, 1023);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
